pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. Consumes hazard-relevant fields from the IF/ID, ID/EX and EX/MEM pipeline registers and the data-memory ready handshake. Drives write-enables and flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Handles load-use stalls, taken-branch flushes (branch resolves in MEM), multi-cycle data-memory waits, and a memory watchdog.

Parameters:
MEM_TIMEOUT, 16, max cycles one data access may wait for dmem_ready before error
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
IFID_rs1  in  5  rs1 field of instruction in IF/ID
IFID_rs2  in  5  rs2 field of instruction in IF/ID
IDEX_rd  in  5  rd (inst2) field in ID/EX
IDEX_MemRead  in  1  ID/EX holds a load
EXMEM_Branch  in  1  EX/MEM holds a branch
EXMEM_ZERO  in  1  branch condition from EX/MEM
EXMEM_MemRead  in  1  MEM-stage load
EXMEM_MemWrite  in  1  MEM-stage store
dmem_ready  in  1  data memory completes current access this cycle
pc_write  out  1  PC update enable
pc_src  out  1  1 = PC loads branch target
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to bubble
idex_flush  out  1  ID/EX clear to bubble
idex_write  out  1  ID/EX load enable
exmem_write  out  1  EX/MEM load enable
exmem_flush  out  1  EX/MEM clear to bubble
memwb_bubble  out  1  MEM/WB loads bubble (RegWrite=0)
dmem_req  out  1  data access request
mem_err  out  1  sticky watchdog error
stall_count  out  CNT_W  cycles with pc_write=0 (excl. error state)
flush_count  out  CNT_W  taken-branch flush events

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Outputs combinational from state+inputs; state, wait counter, perf counters, mem_err registered.
- Reset (asserted, async): state=RUN, wait counter=0, counters=0, mem_err=0. While reset high: all *_write=0, pc_src=0, all flush/bubble=1, dmem_req=0.
- Definitions: mem_acc = EXMEM_MemRead|EXMEM_MemWrite; br_taken = EXMEM_Branch & EXMEM_ZERO; load_use = IDEX_MemRead & IDEX_rd!=0 & (IDEX_rd==IFID_rs1 | IDEX_rd==IFID_rs2).
- dmem_req = mem_acc in RUN/MEM_WAIT; 0 in ERROR.
- RUN default: all write enables 1, flushes/bubble 0, pc_src 0.
- RUN priority 1, mem_acc & !dmem_ready: go MEM_WAIT; this cycle pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1; wait counter <= 1.
- RUN priority 2, br_taken: pc_src=1, pc_write=1, ifid_flush=idex_flush=exmem_flush=1; flush_count+1. Overrides load_use (no stall that cycle).
- RUN priority 3, load_use: pc_write=0, ifid_write=0, idex_flush=1; others advance. Exactly one bubble per hazard.
- Zero-wait access (mem_acc & dmem_ready in RUN): no stall.
- MEM_WAIT, !dmem_ready: freeze as above, counter+1; if counter==MEM_TIMEOUT-1 -> ERROR, mem_err<=1.
- MEM_WAIT, dmem_ready: -> RUN, counter<=0; that cycle all stages advance, memwb_bubble=0; branch/load-use rules evaluated as in RUN (except priority 1).
- ERROR: all writes 0, memwb_bubble=1, dmem_req=0, mem_err=1; exit only by reset.
- stall_count +1 every cycle pc_write=0 outside ERROR and reset; flush_count per br_taken cycle. Both wrap at 2^CNT_W.
- Reset mid-MEM_WAIT: immediate return to RUN, counter cleared.

Test Plan:
- lw x5 in ID/EX, IFID_rs1=5 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; stall_count=1; next cycle all enables 1.
- IDEX_rd=0 with IDEX_MemRead=1, IFID_rs2=0 -> no stall.
- EXMEM_Branch=1, ZERO=1 with load_use also true -> pc_src=1, three flushes, pc_write=1, flush_count=1, stall_count unchanged.
- EXMEM_MemRead=1, dmem_ready low 3 cycles then high -> 3 freeze cycles (memwb_bubble=1, dmem_req=1), 4th cycle advance; stall_count=3.
- MEM_TIMEOUT=4, dmem_ready held low -> ERROR after 4 wait cycles, mem_err=1 sticky, dmem_req=0; reset clears it.
- Assert reset during MEM_WAIT -> outputs go to reset values same cycle, state RUN after release, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RISC-V pipeline: load-use stalls,
// MEM-stage branch flushes, multi-cycle data-memory waits and a watchdog.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             EXMEM_Branch,
  input  logic             EXMEM_ZERO,
  input  logic             EXMEM_MemRead,
  input  logic             EXMEM_MemWrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  // A load in ID/EX whose rd feeds the instruction in IF/ID; x0 never hazards.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    load_use_hit = mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  state_t            state_r, state_nxt_s;
  logic [WAIT_W-1:0] wait_r, wait_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              mem_err_r, set_err_s, flush_ev_s;

  logic mem_acc_s, br_taken_s, load_use_s;
  logic pc_write_s, pc_src_s, ifid_write_s, ifid_flush_s, idex_flush_s;
  logic idex_write_s, exmem_write_s, exmem_flush_s, memwb_bubble_s, dmem_req_s;

  assign mem_acc_s  = EXMEM_MemRead | EXMEM_MemWrite;
  assign br_taken_s = EXMEM_Branch & EXMEM_ZERO;
  assign load_use_s = load_use_hit(IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2);

  // Next-state, wait counter and pipeline controls from state and hazards.
  always_comb begin
    state_nxt_s    = state_r;
    wait_nxt_s     = wait_r;
    set_err_s      = 1'b0;
    flush_ev_s     = 1'b0;
    pc_write_s     = 1'b1;
    pc_src_s       = 1'b0;
    ifid_write_s   = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_flush_s   = 1'b0;
    idex_write_s   = 1'b1;
    exmem_write_s  = 1'b1;
    exmem_flush_s  = 1'b0;
    memwb_bubble_s = 1'b0;
    dmem_req_s     = mem_acc_s;

    case (state_r)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_acc_s && !dmem_ready) begin
          // Freeze everything up to EX/MEM while the access is outstanding.
          pc_write_s     = 1'b0;
          ifid_write_s   = 1'b0;
          idex_write_s   = 1'b0;
          exmem_write_s  = 1'b0;
          memwb_bubble_s = 1'b1;
          if (state_r == ST_RUN) begin
            state_nxt_s = ST_MEM_WAIT;
            wait_nxt_s  = WAIT_ONE;
          end else if (wait_r >= WAIT_LAST) begin
            state_nxt_s = ST_ERROR;
            wait_nxt_s  = wait_r + WAIT_ONE;
            set_err_s   = 1'b1;
          end else begin
            wait_nxt_s  = wait_r + WAIT_ONE;
          end
        end else begin
          state_nxt_s = ST_RUN;
          wait_nxt_s  = '0;
          if (br_taken_s) begin
            pc_src_s      = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
            flush_ev_s    = 1'b1;
          end else if (load_use_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
          end else begin
            pc_src_s = 1'b0;
          end
        end
      end
      ST_ERROR: begin
        pc_write_s     = 1'b0;
        ifid_write_s   = 1'b0;
        idex_write_s   = 1'b0;
        exmem_write_s  = 1'b0;
        memwb_bubble_s = 1'b1;
        dmem_req_s     = 1'b0;
      end
      default: begin
        state_nxt_s    = ST_RUN;
        wait_nxt_s     = '0;
        pc_write_s     = 1'b0;
        ifid_write_s   = 1'b0;
        idex_write_s   = 1'b0;
        exmem_write_s  = 1'b0;
        memwb_bubble_s = 1'b1;
        dmem_req_s     = 1'b0;
      end
    endcase
  end

  // While reset is high the pipeline is held with bubbles in every stage.
  assign pc_write     = reset ? 1'b0 : pc_write_s;
  assign pc_src       = reset ? 1'b0 : pc_src_s;
  assign ifid_write   = reset ? 1'b0 : ifid_write_s;
  assign ifid_flush   = reset ? 1'b1 : ifid_flush_s;
  assign idex_flush   = reset ? 1'b1 : idex_flush_s;
  assign idex_write   = reset ? 1'b0 : idex_write_s;
  assign exmem_write  = reset ? 1'b0 : exmem_write_s;
  assign exmem_flush  = reset ? 1'b1 : exmem_flush_s;
  assign memwb_bubble = reset ? 1'b1 : memwb_bubble_s;
  assign dmem_req     = reset ? 1'b0 : dmem_req_s;

  assign mem_err     = mem_err_r;
  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;

  // State, watchdog counter, sticky error and wrapping performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_RUN;
      wait_r      <= '0;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      wait_r    <= wait_nxt_s;
      mem_err_r <= mem_err_r | set_err_s;
      if (!pc_write_s && (state_r != ST_ERROR)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_ev_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven checks of pipe_hazard_ctrl plus hand-written
// multi-cycle sequences for memory waits, watchdog and reset.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic idex_mr, exm_br, exm_zero, exm_mr, exm_mw, dmem_ready;
  logic pc_write, pc_src, ifid_write, ifid_flush, idex_flush, idex_write;
  logic exmem_write, exmem_flush, memwb_bubble, dmem_req, mem_err;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [9:0] outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .IFID_rs1(ifid_rs1), .IFID_rs2(ifid_rs2), .IDEX_rd(idex_rd),
    .IDEX_MemRead(idex_mr), .EXMEM_Branch(exm_br), .EXMEM_ZERO(exm_zero),
    .EXMEM_MemRead(exm_mr), .EXMEM_MemWrite(exm_mw), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .idex_write(idex_write),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .dmem_req(dmem_req), .mem_err(mem_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // {pc_write,pc_src,ifid_write,ifid_flush,idex_flush,idex_write,exmem_write,exmem_flush,memwb_bubble,dmem_req}
  assign outs = {pc_write, pc_src, ifid_write, ifid_flush, idex_flush,
                 idex_write, exmem_write, exmem_flush, memwb_bubble, dmem_req};

  localparam logic [9:0] O_RUN    = 10'b1010011000;
  localparam logic [9:0] O_RUN_MR = 10'b1010011001;
  localparam logic [9:0] O_LU     = 10'b0000111000;
  localparam logic [9:0] O_BR     = 10'b1111111100;
  localparam logic [9:0] O_FRZ    = 10'b0000000011;
  localparam logic [9:0] O_ERR    = 10'b0000000010;
  localparam logic [9:0] O_RST    = 10'b0001100110;
  localparam logic [9:0] M_ALL    = 10'b1111111111;
  localparam logic [9:0] M_ERR    = 10'b1110011011;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       idmr, br, z, mr, mw, rdy;
    logic [9:0] exp;
    int         stall, flush;
  } vec_t;

  vec_t tbl[10];

  task automatic chk_outs(input string name, input logic [9:0] exp, input logic [9:0] mask);
    checks++;
    if ((outs & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: outs got %b expected %b (mask %b)", name, outs, exp, mask);
    end
  endtask

  task automatic chk_val(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic idmr, input logic br, input logic z,
                       input logic mr, input logic mw, input logic rdy);
    @(negedge clk);
    ifid_rs1 = rs1; ifid_rs2 = rs2; idex_rd = rd; idex_mr = idmr;
    exm_br = br; exm_zero = z; exm_mr = mr; exm_mw = mw; dmem_ready = rdy;
    #1;
  endtask

  initial begin
    tbl[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN,    0, 0};
    tbl[1] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_LU,     0, 0};
    tbl[2] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN,    1, 0};
    tbl[3] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN,    1, 0};
    tbl[4] = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_LU,     1, 0};
    tbl[5] = '{5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN,    2, 0};
    tbl[6] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_BR,     2, 0};
    tbl[7] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN,    2, 1};
    tbl[8] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN_MR, 2, 1};
    tbl[9] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN,    2, 1};

    reset = 1'b1;
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0; idex_mr = 1'b0;
    exm_br = 1'b0; exm_zero = 1'b0; exm_mr = 1'b0; exm_mw = 1'b0; dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_outs("reset_outs", O_RST, M_ALL);
    chk_val("reset_stall", stall_count, 0);
    chk_val("reset_flush", flush_count, 0);
    chk_val("reset_err", {31'd0, mem_err}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].idmr, tbl[i].br, tbl[i].z,
            tbl[i].mr, tbl[i].mw, tbl[i].rdy);
      chk_outs($sformatf("vec%0d_outs", i), tbl[i].exp, M_ALL);
      chk_val($sformatf("vec%0d_stall", i), stall_count, tbl[i].stall);
      chk_val($sformatf("vec%0d_flush", i), flush_count, tbl[i].flush);
    end

    // Three wait cycles then completion, with a taken branch on the release cycle.
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_outs($sformatf("wait%0d_outs", i), O_FRZ, M_ALL);
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_outs("wait_release_outs", O_BR | 10'b0000000001, M_ALL);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("after_wait_outs", O_RUN, M_ALL);
    chk_val("after_wait_stall", stall_count, 5);
    chk_val("after_wait_flush", flush_count, 2);

    // Watchdog: four frozen cycles then sticky ERROR.
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_outs($sformatf("wd%0d_outs", i), O_FRZ, M_ALL);
      chk_val($sformatf("wd%0d_err", i), {31'd0, mem_err}, 0);
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_outs("err_outs", O_ERR, M_ERR);
    chk_val("err_flag", {31'd0, mem_err}, 1);
    chk_val("err_stall", stall_count, 9);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_outs("err_hold_outs", O_ERR, M_ERR);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("err_sticky_outs", O_ERR, M_ERR);
    chk_val("err_sticky_flag", {31'd0, mem_err}, 1);
    chk_val("err_sticky_stall", stall_count, 9);
    chk_val("err_sticky_flush", flush_count, 2);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_outs("err_reset_outs", O_RST, M_ALL);
    chk_val("err_reset_flag", {31'd0, mem_err}, 0);
    chk_val("err_reset_stall", stall_count, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_outs("post_err_reset_outs", O_RUN, M_ALL);

    // Reset in the middle of a memory wait returns straight to RUN.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_outs("midwait_outs", O_FRZ, M_ALL);
    chk_val("midwait_stall", stall_count, 1);
    reset = 1'b1;
    #1;
    chk_outs("midwait_reset_outs", O_RST, M_ALL);
    chk_val("midwait_reset_stall", stall_count, 0);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_outs("midwait_run_outs", O_RUN, M_ALL);
    chk_val("midwait_run_stall", stall_count, 0);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_outs("midwait_run2_outs", O_RUN, M_ALL);
    chk_val("midwait_run2_flush", flush_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
